// File: rtl/dff_input_conditioner_pkg.sv
// Shared types and elaboration limits for the D-input conditioner.
package dff_cond_pkg;
  typedef enum logic {STABLE, CONFIRM} state_e;

  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;
  localparam int unsigned DEBOUNCE_MIN    = 2;
  localparam int unsigned DEBOUNCE_MAX    = 65535;
endpackage

// File: rtl/dff_input_conditioner_if.sv
// Raw input level and conditioned outputs of the D-input conditioner.
interface dff_input_conditioner_if;
  logic din;
  logic q;
  logic rise;
  logic fall;
  logic busy;

  modport master (output din, input q, rise, fall, busy);
  modport slave  (input din, output q, rise, fall, busy);
endinterface

// File: rtl/dff_input_conditioner_sync_chain.sv
// Plain flop chain bringing an asynchronous level into the clk domain.
module sync_chain #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], d};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/dff_input_conditioner.sv
// Synchronises and debounces a raw level into a clean registered q,
// with one-cycle rise/fall pulses on each accepted change.
module dff_input_conditioner
  import dff_cond_pkg::*;
#(
  parameter  int unsigned SYNC_STAGES     = 2,
  parameter  int unsigned DEBOUNCE_CYCLES = 4,
  localparam int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  dff_input_conditioner_if.slave   bus
);
  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
    $error("dff_input_conditioner: SYNC_STAGES out of range 2..4");
  end
  if (DEBOUNCE_CYCLES < DEBOUNCE_MIN || DEBOUNCE_CYCLES > DEBOUNCE_MAX) begin : g_bad_deb
    $error("dff_input_conditioner: DEBOUNCE_CYCLES out of range 2..65535");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s_out;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_q, q_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;

  sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.din),
    .q   (s_out)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      STABLE: begin
        if (s_out != q_q) begin
          state_d = CONFIRM;
          cnt_d   = CNT_W'(1);
          busy_d  = 1'b1;
        end else begin
          cnt_d = '0;
        end
      end
      CONFIRM: begin
        if (s_out == q_q) begin
          // level fell back before confirmation: drop the candidate silently
          state_d = STABLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          q_d     = ~q_q;
          rise_d  = ~q_q;
          fall_d  = q_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.rise = rise_q;
  assign bus.fall = fall_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_dff_input_conditioner.sv
// Bench for dff_input_conditioner: two parameter sets checked every cycle
// against a run-length model, plus hand-computed latency points.
module tb_dff_input_conditioner;
  logic clk = 1'b0;
  logic rst = 1'b1;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  dff_input_conditioner_if if_a ();
  dff_input_conditioner_if if_b ();

  dff_input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  dff_input_conditioner #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  always #25 clk = ~clk;

  // Model: s_out seen at an edge is din sampled SYNC_STAGES edges earlier.
  // q flips once s_out has disagreed with q on DEBOUNCE_CYCLES consecutive edges.
  int unsigned ms [2] = '{2, 3};
  int unsigned md [2] = '{4, 2};
  logic [3:0]  sh [2];
  int unsigned run [2];
  logic        mq [2];
  logic        mrise [2];
  logic        mfall [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      sh[k] = '0; run[k] = 0; mq[k] = 1'b0; mrise[k] = 1'b0; mfall[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input logic d);
    logic s_pre;
    s_pre = sh[k][ms[k]-1];
    mrise[k] = 1'b0;
    mfall[k] = 1'b0;
    if (s_pre != mq[k]) begin
      run[k] = run[k] + 1;
      if (run[k] == md[k]) begin
        mq[k]    = ~mq[k];
        mrise[k] = mq[k];
        mfall[k] = ~mq[k];
        run[k]   = 0;
      end
    end else begin
      run[k] = 0;
    end
    sh[k] = {sh[k][2:0], d};
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else begin
        model_step(0, if_a.din);
        model_step(1, if_b.din);
      end
    end
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk("a_q",    if_a.q,    mq[0]);
      chk("a_rise", if_a.rise, mrise[0]);
      chk("a_fall", if_a.fall, mfall[0]);
      chk("a_busy", if_a.busy, run[0] != 0);
      chk("b_q",    if_b.q,    mq[1]);
      chk("b_rise", if_b.rise, mrise[1]);
      chk("b_fall", if_b.fall, mfall[1]);
      chk("b_busy", if_b.busy, run[1] != 0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    if_a.din = 1'b1;
    if_b.din = 1'b1;
    cyc(3);
    chk("rst_q",    if_a.q,    1'b0);
    chk("rst_rise", if_a.rise, 1'b0);
    chk("rst_fall", if_a.fall, 1'b0);
    chk("rst_busy", if_a.busy, 1'b0);
    rst = 1'b0;
    cyc(5);
    chk("rel_e5_q",    if_a.q,    1'b0);
    chk("rel_e5_busy", if_a.busy, 1'b1);
    chk("b_rel_e5_q",    if_b.q,    1'b1);
    chk("b_rel_e5_rise", if_b.rise, 1'b1);
    cyc(1);
    chk("rel_e6_q",    if_a.q,    1'b1);
    chk("rel_e6_rise", if_a.rise, 1'b1);
    cyc(1);
    chk("rel_e7_rise", if_a.rise, 1'b0);

    // clean fall
    if_a.din = 1'b0;
    cyc(5);
    chk("fall_e5_q", if_a.q, 1'b1);
    cyc(1);
    chk("fall_e6_q",    if_a.q,    1'b0);
    chk("fall_e6_fall", if_a.fall, 1'b1);
    cyc(1);
    chk("fall_e7_fall", if_a.fall, 1'b0);

    // clean rise
    if_a.din = 1'b1;
    cyc(2);
    chk("rise_e2_busy", if_a.busy, 1'b0);
    cyc(1);
    chk("rise_e3_busy", if_a.busy, 1'b1);
    cyc(2);
    chk("rise_e5_busy", if_a.busy, 1'b1);
    chk("rise_e5_q",    if_a.q,    1'b0);
    cyc(1);
    chk("rise_e6_q",    if_a.q,    1'b1);
    chk("rise_e6_rise", if_a.rise, 1'b1);
    chk("rise_e6_busy", if_a.busy, 1'b0);
    cyc(1);
    chk("rise_e7_rise", if_a.rise, 1'b0);
    chk("rise_e7_fall", if_a.fall, 1'b0);
    if_a.din = 1'b0;
    cyc(8);
    chk("pre_glitch_q", if_a.q, 1'b0);

    // glitch of two cycles on instance A
    if_a.din = 1'b1;
    cyc(2);
    if_a.din = 1'b0;
    cyc(1);
    chk("glitch_e3_busy", if_a.busy, 1'b1);
    cyc(2);
    chk("glitch_e5_busy", if_a.busy, 1'b0);
    chk("glitch_e5_cnt0", dut_a.cnt_q == '0, 1'b1);
    cyc(5);
    chk("glitch_q", if_a.q, 1'b0);

    // SYNC_STAGES=3, DEBOUNCE_CYCLES=2: 1-cycle pulse rejected, 2-cycle accepted
    if_b.din = 1'b0;
    cyc(8);
    chk("b_low_q", if_b.q, 1'b0);
    if_b.din = 1'b1;
    cyc(1);
    if_b.din = 1'b0;
    cyc(8);
    chk("b_pulse1_q", if_b.q, 1'b0);
    if_b.din = 1'b1;
    cyc(2);
    if_b.din = 1'b0;
    cyc(3);
    chk("b_pulse2_q",    if_b.q,    1'b1);
    chk("b_pulse2_rise", if_b.rise, 1'b1);
    cyc(10);

    // reset mid-confirmation on instance A
    if_a.din = 1'b1;
    cyc(4);
    chk("mid_e4_busy", if_a.busy, 1'b1);
    #5 rst = 1'b1;
    #1;
    chk("mid_rst_q",    if_a.q,    1'b0);
    chk("mid_rst_busy", if_a.busy, 1'b0);
    chk("mid_rst_cnt0", dut_a.cnt_q == '0, 1'b1);
    if_a.din = 1'b0;
    if_b.din = 1'b0;
    cyc(1);
    rst = 1'b0;
    cyc(10);
    chk("mid_after_q", if_a.q, 1'b0);

    // randomized hold lengths with occasional asynchronous resets
    for (int i = 0; i < 400; i++) begin
      if_a.din = 1'($urandom_range(0, 1));
      if_b.din = 1'($urandom_range(0, 1));
      cyc($urandom_range(1, 7));
      if ($urandom_range(0, 39) == 0) begin
        #($urandom_range(1, 20));
        rst = 1'b1;
        #1;
        chk("rnd_rst_q",    if_a.q,    1'b0);
        chk("rnd_rst_busy", if_a.busy, 1'b0);
        chk("rnd_rst_b_q",  if_b.q,    1'b0);
        @(negedge clk);
        rst = 1'b0;
      end
    end
    cyc(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/dff_input_conditioner.md
Name: dff_input_conditioner

Overview:
- Upstream stage for the rising-edge D flip-flop data input.
- Takes an asynchronous, possibly bouncy level `din`, synchronises it into the `clk` domain and debounces it.
- Presents a clean registered level `q`, ready to drive the flip-flop's D pin.
- Also produces single-cycle rise/fall pulses for downstream event logic.

Parameters:
- SYNC_STAGES, 2: number of synchroniser flops; legal range 2..4.
- DEBOUNCE_CYCLES, 4: number of consecutive synchronised cycles a new level must hold before `q` changes; legal range 2..65535.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): width of the debounce counter; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock, 50 ns period in the bench.
- rst  input  1  asynchronous, active-high reset.
- din  input  1  asynchronous raw input level.
- q  output  1  debounced, synchronised level; feeds the flip-flop D input.
- rise  output  1  one-cycle pulse when `q` goes 0->1.
- fall  output  1  one-cycle pulse when `q` goes 1->0.
- busy  output  1  high while a candidate level change is being confirmed.

Behaviour:
- Reset: asserting `rst` at any time, including mid-confirmation, immediately clears all of the following, with no clock needed:
  - synchroniser flops to 0;
  - counter to 0;
  - FSM to STABLE;
  - q=0, rise=0, fall=0, busy=0.
- Reset release: first active edge is the first `clk` rising edge after `rst` falls. A candidate change in progress at reset is discarded.
- Synchroniser: a chain of SYNC_STAGES flops. `s_out` is the last stage. There is no logic between stages.
- FSM states:
  - STABLE:
    - if s_out==q: stay, counter held at 0.
    - if s_out!=q: go to CONFIRM, counter<=1, busy<=1.
  - CONFIRM, s_out!=q:
    - counter<DEBOUNCE_CYCLES-1: counter<=counter+1.
    - counter==DEBOUNCE_CYCLES-1: q<=~q, rise or fall<=1 per the new q value, counter<=0, busy<=0, go to STABLE.
  - CONFIRM, s_out==q (glitch): go to STABLE, counter<=0, busy<=0, q unchanged, no pulse.
- Latency:
  - Count the first edge that samples a new stable `din` as edge 1.
  - `s_out` shows the new level after edge SYNC_STAGES.
  - `q` changes on edge SYNC_STAGES+DEBOUNCE_CYCLES; with the defaults this is edge 6.
- Pulses:
  - `rise`/`fall` are registered and change on the same edge as `q`.
  - Each is high for exactly one clock cycle.
  - They are never high together, and never high without a `q` change.
- Counter:
  - Never exceeds DEBOUNCE_CYCLES-1.
  - Never wraps.
  - Is 0 whenever the FSM is in STABLE.
- Any pulse on `din` shorter than DEBOUNCE_CYCLES synchronised cycles is rejected.
- Back-to-back changes: after a toggle, a further change re-enters CONFIRM no earlier than the next edge, so the minimum spacing between `q` changes is DEBOUNCE_CYCLES cycles.
- Outputs depend only on registers; there is no combinational path from `din` to any output.

Decomposition:
- Package `dff_cond_pkg`:
  - state enum `{STABLE, CONFIRM}`;
  - constants SYNC_STAGES_MIN=2 and DEBOUNCE_MIN=2, used by elaboration-time parameter checks.
- One sub-module, `sync_chain`:
  - parameterised by SYNC_STAGES;
  - ports clk, rst, d, q;
  - instantiated once.
- FSM, counter and pulse logic live in the top module.

Test Plan:
- Reset: hold rst=1 for 3 cycles with din=1, then deassert -> q=0, rise=0, fall=0, busy=0 during reset. With din held at 1, q=1 and rise=1 on edge 6 after release, with a one-cycle rise pulse.
- Clean rise (defaults, din 0->1, held 100 ns steps) -> busy=1 from edge 3 to edge 5; q=1 and rise=1 after edge 6; rise=0 after edge 7; fall stays 0.
- Glitch: din=1 for 2 clock cycles then back to 0 -> busy pulses high, q stays 0, rise and fall stay 0, counter returns to 0.
- Clean fall from q=1: din 1->0 held -> q=0 and fall=1 after edge 6; fall is high for exactly 1 cycle.
- Reset mid-confirm: din 0->1, assert rst asynchronously between edges 4 and 5 -> q, busy and counter drop to 0 immediately without waiting for a clock edge; no rise pulse is ever emitted for that change.
- Parameter sweep: SYNC_STAGES=3, DEBOUNCE_CYCLES=2 -> q changes on edge 5. A 1-cycle din pulse is rejected; a 2-cycle pulse is accepted.
